// File: rtl/dc_motor_pwm_mc.sv
// dc_motor_pwm_mc - multi-channel DC motor PWM slave on Avalon-MM.
// Each channel has double-buffered PERIOD/DUTY registers and a STOP/RUN/DEAD
// sequencer that inserts a dead-time coast on a running direction reversal.
// pwm/in1/in2 are registered and show the state of the previous cycle.
// Optional build macro: DC_MOTOR_PWM_IRQ_EN adds per-channel period_done
// sticky flags, CONTROL.irq_en and the irq output. Without it irq is tied low.
module dc_motor_pwm_mc #(
    parameter int  CHANNELS  = 2,
    parameter int  CNT_W     = 16,
    parameter int  DEAD_CLKS = 64,
    localparam int AW        = $clog2(CHANNELS) + 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                s_cs,
    input  logic [AW-1:0]       s_address,
    input  logic                s_write,
    input  logic [31:0]         s_writedata,
    input  logic                s_read,
    output logic [31:0]         s_readdata,
    output logic [CHANNELS-1:0] pwm,
    output logic [CHANNELS-1:0] in1,
    output logic [CHANNELS-1:0] in2,
    output logic                irq
);

    localparam int               DW        = (DEAD_CLKS > 1) ? $clog2(DEAD_CLKS) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0]    DEAD_ZERO = {DW{1'b0}};
    localparam logic [DW-1:0]    DEAD_ONE  = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0]    DEAD_LAST = DW'(DEAD_CLKS - 32'sd1);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    logic [31:0]               addr_ch_s;
    logic [1:0]                reg_sel_s;
    logic [CHANNELS-1:0][31:0] ch_rd_s;
    logic [CHANNELS-1:0]       pd_vec_s;
    logic [CHANNELS-1:0]       ien_vec_s;
    logic [31:0]               rd_sel_s;
    logic [31:0]               readdata_r;
    logic                      unused_wd_s;

    // channel index is everything above the two register-select bits
    assign addr_ch_s   = 32'(s_address) >> 2'd2;
    assign reg_sel_s   = s_address[1:0];
    // upper write-data bits are architecturally ignored
    assign unused_wd_s = ^s_writedata;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [CNT_W-1:0] per_stg_r, dut_stg_r, per_sh_r, dut_sh_r;
        logic [CNT_W-1:0] tick_r, tick_nx_s;
        logic [DW-1:0]    dead_r, dead_nx_s;
        state_t           state_r, state_nx_s;
        logic [1:0]       state_bits_s;
        logic             go_r, fwd_r, fd_r;
        logic             go_nx_s, fwd_nx_s;
        logic             sel_s, wr_per_s, wr_dut_s, wr_ctl_s;
        logic             period_end_s, raw_pwm_s;
        logic             pwm_r, in1_r, in2_r;
        logic             ien_s, pd_s;
        logic [31:0]      rd_val_s;

        assign sel_s    = s_cs && (addr_ch_s == 32'(c));
        assign wr_per_s = sel_s && s_write && (reg_sel_s == 2'd0);
        assign wr_dut_s = sel_s && s_write && (reg_sel_s == 2'd1);
        assign wr_ctl_s = sel_s && s_write && (reg_sel_s == 2'd2);

        // control values as they will be after this edge; the sequencer reacts to the write itself
        assign go_nx_s  = wr_ctl_s ? s_writedata[0] : go_r;
        assign fwd_nx_s = wr_ctl_s ? s_writedata[1] : fwd_r;

        assign period_end_s = (state_r == ST_RUN) && (per_sh_r != CNT_ZERO) && (tick_r >= per_sh_r);
        assign raw_pwm_s    = (state_r == ST_RUN) && (per_sh_r != CNT_ZERO) && (tick_r <= dut_sh_r);
        assign state_bits_s = state_r;

        // staging and control registers written from the bus
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                per_stg_r <= CNT_ZERO;
                dut_stg_r <= CNT_ZERO;
                go_r      <= 1'b0;
                fwd_r     <= 1'b0;
                fd_r      <= 1'b1;
            end else begin
                if (wr_per_s) per_stg_r <= s_writedata[CNT_W-1:0];
                if (wr_dut_s) dut_stg_r <= s_writedata[CNT_W-1:0];
                if (wr_ctl_s) begin
                    go_r  <= s_writedata[0];
                    fwd_r <= s_writedata[1];
                    fd_r  <= s_writedata[2];
                end
            end
        end

        // shadow copy only at a period boundary, or continuously when not running
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                per_sh_r <= CNT_ZERO;
                dut_sh_r <= CNT_ZERO;
            end else if ((state_r != ST_RUN) || period_end_s) begin
                per_sh_r <= per_stg_r;
                dut_sh_r <= dut_stg_r;
            end else begin
                per_sh_r <= per_sh_r;
                dut_sh_r <= dut_sh_r;
            end
        end

        // sequencer next-state, tick and dead-time counter
        always_comb begin
            state_nx_s = state_r;
            dead_nx_s  = dead_r;
            tick_nx_s  = CNT_ONE;
            case (state_r)
                ST_STOP: begin
                    if (go_nx_s) state_nx_s = ST_RUN;
                    else         state_nx_s = ST_STOP;
                end
                ST_RUN: begin
                    if (!go_nx_s) begin
                        state_nx_s = ST_STOP;
                    end else if (fwd_nx_s != fwd_r) begin
                        state_nx_s = ST_DEAD;
                        dead_nx_s  = DEAD_ZERO;
                    end else if (period_end_s || (per_sh_r == CNT_ZERO)) begin
                        tick_nx_s  = CNT_ONE;
                    end else begin
                        tick_nx_s  = tick_r + CNT_ONE;
                    end
                end
                ST_DEAD: begin
                    if (!go_nx_s) begin
                        state_nx_s = ST_STOP;
                    end else if (fwd_nx_s != fwd_r) begin
                        dead_nx_s  = DEAD_ZERO;
                    end else if (dead_r == DEAD_LAST) begin
                        state_nx_s = ST_RUN;
                    end else begin
                        dead_nx_s  = dead_r + DEAD_ONE;
                    end
                end
                default: state_nx_s = ST_STOP;
            endcase
        end

        // sequencer state register
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_r <= ST_STOP;
                tick_r  <= CNT_ONE;
                dead_r  <= DEAD_ZERO;
            end else begin
                state_r <= state_nx_s;
                tick_r  <= tick_nx_s;
                dead_r  <= dead_nx_s;
            end
        end

        // registered bridge outputs; brake out of reset
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                pwm_r <= 1'b0;
                in1_r <= 1'b1;
                in2_r <= 1'b1;
            end else begin
                pwm_r <= raw_pwm_s;
                case (state_r)
                    ST_STOP: begin
                        in1_r <= fd_r;
                        in2_r <= fd_r;
                    end
                    ST_RUN: begin
                        in1_r <= !fwd_r;
                        in2_r <= fwd_r;
                    end
                    default: begin
                        in1_r <= 1'b0;
                        in2_r <= 1'b0;
                    end
                endcase
            end
        end

`ifdef DC_MOTOR_PWM_IRQ_EN
        logic wr_sts_s, ien_r, pd_r;
        assign wr_sts_s = sel_s && s_write && (reg_sel_s == 2'd3);

        // interrupt enable and sticky period_done; a set beats a same-cycle clear
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                ien_r <= 1'b0;
                pd_r  <= 1'b0;
            end else begin
                if (wr_ctl_s) ien_r <= s_writedata[3];
                pd_r <= period_end_s | (pd_r & ~(wr_sts_s & s_writedata[2]));
            end
        end
        assign ien_s = ien_r;
        assign pd_s  = pd_r;
`else
        assign ien_s = 1'b0;
        assign pd_s  = 1'b0;
`endif

        // per-channel register readback
        always_comb begin
            rd_val_s = 32'd0;
            case (reg_sel_s)
                2'd0:    rd_val_s = 32'(per_stg_r);
                2'd1:    rd_val_s = 32'(dut_stg_r);
                2'd2:    rd_val_s = {28'd0, ien_s, fd_r, fwd_r, go_r};
                2'd3:    rd_val_s = {29'd0, pd_s, state_bits_s};
                default: rd_val_s = 32'd0;
            endcase
        end

        assign ch_rd_s[c]   = rd_val_s;
        assign pd_vec_s[c]  = pd_s;
        assign ien_vec_s[c] = ien_s;
        assign pwm[c]       = pwm_r;
        assign in1[c]       = in1_r;
        assign in2[c]       = in2_r;
    end

    // select the addressed channel; unimplemented channels read zero
    always_comb begin
        rd_sel_s = 32'd0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (addr_ch_s == 32'(i)) rd_sel_s = ch_rd_s[i];
            else                     rd_sel_s = rd_sel_s;
        end
    end

    // read data register, updated only on a qualified read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)            readdata_r <= 32'd0;
        else if (s_cs && s_read) readdata_r <= rd_sel_s;
        else                     readdata_r <= readdata_r;
    end
    assign s_readdata = readdata_r;

`ifdef DC_MOTOR_PWM_IRQ_EN
    logic irq_r;
    // registered OR of enabled period_done flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq_r <= 1'b0;
        else          irq_r <= |(pd_vec_s & ien_vec_s);
    end
    assign irq = irq_r;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: doc/dc_motor_pwm_mc.md
Name: dc_motor_pwm_mc

Overview:
- Multi-channel successor to the single-channel DC motor PWM slave on the Avalon-MM bus of the balance-car Qsys system.
- Drives CHANNELS H-bridge motor drivers. Each channel has:
  - PWM output plus IN1/IN2 direction pins,
  - double-buffered period/duty (updated only at period boundaries, so no glitches),
  - a dead-time coast interval inserted on direction reversal while running.
- Used to drive the left and right wheel motors from one slave.

Parameters:
- CHANNELS, 2, number of motor channels (1..8).
- CNT_W, 16, width of the period/duty/tick counters (8..32).
- DEAD_CLKS, 64, coast duration in clk cycles on a running direction reversal (>=1).
- AW, $clog2(CHANNELS)+2, s_address width (derived; not overridden).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- s_cs  in  1  slave chip select.
- s_address  in  AW  {channel, reg[1:0]}; reg 0=PERIOD, 1=DUTY, 2=CONTROL, 3=STATUS.
- s_write  in  1  write strobe, qualified by s_cs.
- s_writedata  in  32  write data; bits above CNT_W are ignored.
- s_read  in  1  read strobe, qualified by s_cs.
- s_readdata  out  32  read data, valid 1 cycle after s_read.
- pwm  out  CHANNELS  per-channel PWM, registered.
- in1  out  CHANNELS  per-channel bridge IN1.
- in2  out  CHANNELS  per-channel bridge IN2.
- irq  out  1  period-end interrupt (only with the optional feature).

Behaviour:
- Reset values:
  - staging and shadow PERIOD/DUTY = 0, tick = 1;
  - CONTROL: go=0, fwd=0, fast_decay=1; state STOP;
  - pwm=0, in1=in2=all ones (brake); s_readdata=0; irq=0.
- CONTROL bits: [0] go, [1] fwd, [2] fast_decay, [3] irq_en. Other bits write-ignored and read 0.
- STATUS (read-only):
  - [1:0] state (0=STOP, 1=RUN, 2=DEAD);
  - [2] period_done sticky flag;
  - [31:16] zero.
- Register access:
  - Writes take effect on the clock edge where s_cs & s_write.
  - Reads: s_readdata is registered on s_cs & s_read, 1-cycle latency. It holds its value otherwise.
  - PERIOD/DUTY reads return the staging value, zero-extended.
  - Addresses for channel >= CHANNELS read 0; writes to them are ignored.
- Counter (per channel):
  - In RUN, tick counts 1..P, where P = shadow period. After tick == P it wraps to 1; that wrap is the period end.
  - P=0: tick is held at 1 and the raw PWM is 0.
  - Raw PWM = (tick <= D) with P != 0, where D = shadow duty. So D=0 gives 0%, and D>=P gives 100%.
  - pwm output = raw PWM registered one clock.
  - Outside RUN: tick is held at 1 and pwm=0.
- Shadow update: staging is copied to shadow on the period-end cycle in RUN, or on every cycle outside RUN.
  - A write on the same cycle as the period end is not taken at that boundary; it applies at the next one.
- State machine (per channel):
  - STOP:
    - in1=in2=fast_decay (1,1 brake or 0,0 coast), pwm=0.
    - go=1 -> RUN with tick=1.
  - RUN:
    - fwd=1 -> in2=1, in1=0; fwd=0 -> in2=0, in1=1; pwm active.
    - go=0 -> STOP on the next cycle.
    - A write changing fwd while go stays 1 -> DEAD.
  - DEAD:
    - in1=in2=0, pwm=0; dead counter counts DEAD_CLKS cycles, then RUN with the new fwd and tick=1.
    - Another fwd change during DEAD restarts the dead counter.
    - go=0 -> STOP immediately.
  - A single write changing both fwd and go 0->1: STOP -> RUN directly, no dead time.
- Reset mid-operation: all state returns to reset values asynchronously; outputs go to brake immediately.

Optional Feature:
- Macro: DC_MOTOR_PWM_IRQ_EN.
- With the macro defined:
  - period_done is set on each RUN period end.
  - Writing 1 to STATUS[2] clears it. If a set and a clear land on the same cycle, the set wins.
  - irq = OR over channels of (period_done & irq_en), registered.
- Without the macro: irq is tied 0, STATUS[2] reads 0, CONTROL[3] reads 0, and no period_done logic is synthesised.

Test Plan:
- ch0 PERIOD=10, DUTY=3, CONTROL=0x3 -> pwm[0] high 3 clks / low 7 clks repeating; in2=1, in1=0.
- While running, write DUTY=7 mid-period -> current period keeps 3 high clks; next period shows 7 high clks; no runt pulse.
- Running fwd, write CONTROL=0x1 with DEAD_CLKS=64 -> in1=in2=0 and pwm=0 for exactly 64 clks, then in1=1, in2=0 and PWM restarts at tick 1.
- Edge values:
  - DUTY=0 -> pwm constantly 0;
  - DUTY=15 with PERIOD=10 -> constantly 1;
  - PERIOD=0 -> pwm 0, no period_done.
- CONTROL=0x0 -> in1=in2=0; CONTROL=0x4 -> in1=in2=1; assert reset_n low mid-RUN -> immediate in=1,1, pwm=0, and all registers read their reset values.
- With DC_MOTOR_PWM_IRQ_EN: ch1 PERIOD=4, CONTROL=0xB -> irq rises after the first period end; write STATUS=0x4 -> irq drops, then re-asserts 4 clks later.
